// File: rtl/serial_bit_pkg.sv
// Shared definitions for the single-wire serial path (transmit and capture ends).
package serial_bit_pkg;

  localparam int unsigned SBT_WIDTH = 8;
  localparam int unsigned SBT_DIV   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    FIN   = 2'd3
  } sbt_state_e;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts 0..DIV-1 while enabled, ticks on the last cycle of each period.
module bit_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_bit_tx.sv
// MSB-first parallel-to-serial driver, each bit held DIV cycles.
// Optional even-parity bit after the data word when SERIAL_BIT_TX_PARITY_EN is defined.
module serial_bit_tx
  import serial_bit_pkg::*;
#(
  parameter int unsigned WIDTH    = SBT_WIDTH,
  parameter int unsigned DIV      = SBT_DIV,
  parameter logic        IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   BW       = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH);

  sbt_state_e       state;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]    bitcnt;
  logic             tick;
  logic             accept;
  logic             running;
`ifdef SERIAL_BIT_TX_PARITY_EN
  logic             par;
`endif

  assign accept  = din_valid && din_ready;
  assign running = (state == SHIFT) || (state == PAR);

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (running),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      bitcnt    <= '0;
      dout      <= IDLE_LVL;
      busy      <= 1'b0;
      done      <= 1'b0;
      din_ready <= 1'b0;
`ifdef SERIAL_BIT_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // FIN also accepts so back-to-back words carry no extra idle cycle
        IDLE, FIN: begin
          if (accept) begin
            state     <= SHIFT;
            sr        <= din;
            bitcnt    <= BW'(1);
            dout      <= din[WIDTH-1];
            busy      <= 1'b1;
            din_ready <= 1'b0;
`ifdef SERIAL_BIT_TX_PARITY_EN
            par       <= ^din;
`endif
          end else begin
            state     <= IDLE;
            dout      <= IDLE_LVL;
            busy      <= 1'b0;
            din_ready <= 1'b1;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (bitcnt == LAST_BIT) begin
`ifdef SERIAL_BIT_TX_PARITY_EN
              state <= PAR;
              dout  <= par;
`else
              state     <= FIN;
              done      <= 1'b1;
              busy      <= 1'b0;
              dout      <= IDLE_LVL;
              din_ready <= 1'b1;
`endif
            end else begin
              sr     <= sr << 1;
              dout   <= sr[WIDTH-2];
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
`ifdef SERIAL_BIT_TX_PARITY_EN
        PAR: begin
          if (tick) begin
            state     <= FIN;
            done      <= 1'b1;
            busy      <= 1'b0;
            dout      <= IDLE_LVL;
            din_ready <= 1'b1;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          dout      <= IDLE_LVL;
          busy      <= 1'b0;
          din_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Directed bench for serial_bit_tx: DIV=4 instance plus a DIV=1 instance on a shared clock/reset.
module tb_serial_bit_tx;

`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] din0, din1;
  logic       v0, v1;
  logic       rdy0, rdy1;
  logic       dout0, dout1;
  logic       busy0, busy1;
  logic       done0, done1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_done = 0;

  serial_bit_tx #(.WIDTH(8), .DIV(4), .IDLE_LVL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .din(din0), .din_valid(v0),
    .din_ready(rdy0), .dout(dout0), .busy(busy0), .done(done0)
  );

  serial_bit_tx #(.WIDTH(8), .DIV(1), .IDLE_LVL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(v1),
    .din_ready(rdy1), .dout(dout1), .busy(busy1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the cycle right after acceptance; walks every bit-time cycle then checks FIN.
  task automatic tx_body(input int sel, input logic [7:0] w, input int div);
    int   n;
    int   b;
    logic exp;
    logic o_dout, o_busy, o_done, o_rdy;
    n = (8 + PB) * div;
    for (int i = 0; i < n; i++) begin
      b = i / div;
      exp = (b < 8) ? w[7 - b] : ^w;
      if (sel == 0) din0 = ~w;
      else          din1 = ~w;
      o_dout = sel ? dout1 : dout0;
      o_busy = sel ? busy1 : busy0;
      o_done = sel ? done1 : done0;
      o_rdy  = sel ? rdy1  : rdy0;
      checks++;
      if (o_dout !== exp) begin
        errors++;
        $display("FAIL dout w=%h cyc%0d: got %b want %b", w, i + 1, o_dout, exp);
      end
      checks++;
      if (o_busy !== 1'b1) begin
        errors++;
        $display("FAIL busy w=%h cyc%0d: got %b want 1", w, i + 1, o_busy);
      end
      checks++;
      if (o_done !== 1'b0) begin
        errors++;
        $display("FAIL done_early w=%h cyc%0d: got %b want 0", w, i + 1, o_done);
      end
      checks++;
      if (o_rdy !== 1'b0) begin
        errors++;
        $display("FAIL ready_busy w=%h cyc%0d: got %b want 0", w, i + 1, o_rdy);
      end
      step();
    end
    o_dout = sel ? dout1 : dout0;
    o_busy = sel ? busy1 : busy0;
    o_done = sel ? done1 : done0;
    o_rdy  = sel ? rdy1  : rdy0;
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_dout !== 1'b0 || o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL fin w=%h: got done=%b busy=%b dout=%b rdy=%b want 1 0 0 1",
               w, o_done, o_busy, o_dout, o_rdy);
    end
    last_done = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({dout0, busy0, done0, rdy0, dout1, busy1, done1, rdy1} !== 8'b0) begin
        errors++;
        $display("FAIL reset_hold: got %b want 00000000",
                 {dout0, busy0, done0, rdy0, dout1, busy1, done1, rdy1});
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL ready_pre_edge: got %b want 0", rdy0);
    end
    step();
    checks++;
    if ({rdy0, rdy1, dout0, busy0, done0} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_release: got rdy0,rdy1,dout,busy,done=%b want 11000",
               {rdy0, rdy1, dout0, busy0, done0});
    end
  endtask

  task automatic send0(input logic [7:0] w);
    din0 = w;
    v0   = 1'b1;
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL ready_idle w=%h: got %b want 1", w, rdy0);
    end
    step();
    v0 = 1'b0;
    tx_body(0, w, 4);
  endtask

  task automatic test_single();
    send0(8'hA5);
    step();
    checks++;
    if ({done0, busy0, dout0, rdy0} !== 4'b0001) begin
      errors++;
      $display("FAIL idle_after: got done,busy,dout,rdy=%b want 0001",
               {done0, busy0, dout0, rdy0});
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    din0 = 8'hFF;
    v0   = 1'b1;
    step();
    tx_body(0, 8'hFF, 4);
    t1   = last_done;
    din0 = 8'h00;
    step();
    v0 = 1'b0;
    tx_body(0, 8'h00, 4);
    checks++;
    if (last_done - t1 !== (8 + PB) * 4 + 1) begin
      errors++;
      $display("FAIL b2b_gap: got %0d want %0d", last_done - t1, (8 + PB) * 4 + 1);
    end
    step();
  endtask

  task automatic test_div1();
    din1 = 8'h3C;
    v1   = 1'b1;
    step();
    v1 = 1'b0;
    tx_body(1, 8'h3C, 1);
    step();
  endtask

  task automatic test_reset_mid();
    din0 = 8'hA5;
    v0   = 1'b1;
    step();
    v0 = 1'b0;
    repeat (12) step();
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_pre: got %b want 1", busy0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dout0, busy0, done0, rdy0} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got dout,busy,done,rdy=%b want 0000",
               {dout0, busy0, done0, rdy0});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_done: got done=%b busy=%b want 0 0", done0, busy0);
      end
    end
    rst_n = 1'b1;
    step();
    send0(8'h81);
    step();
  endtask

  task automatic test_parity();
    send0(8'h07);
    step();
  endtask

  initial begin
    din0 = '0; din1 = '0; v0 = 1'b0; v1 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_div1();
    test_reset_mid();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
